// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipelined MIPS core.
//   word_t        32-bit machine word
//   fetch_state_t IF stage controller states
//   NOP_INSTR     encoding inserted as a pipeline bubble (sll r0,r0,0)
//   ifid_t        IF/ID pipeline register contents
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;
endpackage

// File: rtl/instr_fetch_stage_ifid_latch.sv
// ifid_latch: IF/ID pipeline register.
//   CLK, nRST   clock (rising edge), async active-low reset (clears to all zero)
//   i_en        load i_d this edge
//   i_flush     clear contents this edge; overrides i_en
//   i_d         next IF/ID contents
//   o_q         registered IF/ID contents
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_en,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);
    ifid_t r_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage + IF/ID latch of the pipelined MIPS core.
// Owns the PC, issues icache reads and latches returned words into IF/ID.
//   CLK, nRST          clock, async active-low reset
//   imemREN/imemaddr   icache request (imemaddr is the PC)
//   ihit/imemload      icache response
//   stall              hold PC and IF/ID
//   flush              squash IF/ID
//   redirect/_pc       branch/jump target load (word aligned internally)
//   halt               decode saw HALT
//   ifid_instr/npc/valid  IF/ID contents to decode
//   halted             fetching stopped (terminal until reset)
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module instr_fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic        halted
);
    fetch_state_t r_state;
    word_t        r_pc;

    logic  w_fetch;
    logic  w_halt_take;
    logic  w_accept;
    logic  w_ifid_en;
    logic  w_ifid_flush;
    word_t w_pc_plus4;
    ifid_t w_ifid_d;
    ifid_t w_ifid_q;
    logic  w_unused_rpc_lo;

    assign w_fetch     = (r_state == FETCH);
    // A HALT seen alongside a flush is wrong-path and must not stop the core.
    assign w_halt_take = w_fetch & halt & ~flush;
    assign w_accept    = w_fetch & ~w_halt_take & ihit & ~stall & ~redirect;
    assign w_pc_plus4  = r_pc + 32'd4;

    // Target low bits are dropped: fetch is always word aligned.
    assign w_unused_rpc_lo = ^redirect_pc[1:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_pc    <= PC_INIT;
        end else begin
            case (r_state)
                IDLE:  r_state <= FETCH;
                FETCH: begin
                    if (w_halt_take)   r_state <= HALT;
                    else if (redirect) r_pc    <= {redirect_pc[31:2], 2'b00};
                    else if (w_accept) r_pc    <= w_pc_plus4;
                end
                default: ;  // HALT: frozen until reset
            endcase
        end
    end

    // IF/ID: load on any non-stalled FETCH edge; anything other than an accept
    // loads a bubble that keeps the previous npc.
    assign w_ifid_en    = w_fetch & ~stall & ~w_halt_take;
    assign w_ifid_flush = w_fetch & flush;
    assign w_ifid_d     = w_accept ? '{instr: imemload, npc: w_pc_plus4, valid: 1'b1}
                                   : '{instr: NOP_INSTR, npc: w_ifid_q.npc, valid: 1'b0};

    ifid_latch u_ifid (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_en    (w_ifid_en),
        .i_flush (w_ifid_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imemREN    = w_fetch;
    assign imemaddr   = r_pc;
    assign ifid_instr = w_ifid_q.instr;
    assign ifid_npc   = w_ifid_q.npc;
    assign ifid_valid = w_ifid_q.valid;
    assign halted     = (r_state == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_accept)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            // Edges that write valid<=0: a flush, or a load that is not an accept.
            if (w_ifid_flush | (w_ifid_en & ~w_accept))
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;
    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    instr_fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles),
`endif
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    endtask

    // Scoreboard: expectation pushed when the step is driven.
    task automatic push(input string tag, input logic ren, input logic [31:0] addr,
                        input logic [31:0] instr, input logic [31:0] npc,
                        input logic valid, input logic hl);
        exp_t e;
        e.tag = tag; e.ren = ren; e.addr = addr; e.instr = instr;
        e.npc = npc; e.valid = valid; e.halted = hl;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "imemREN",    {31'b0, imemREN},    {31'b0, e.ren});
            chk(e.tag, "imemaddr",   imemaddr,            e.addr);
            chk(e.tag, "ifid_instr", ifid_instr,          e.instr);
            chk(e.tag, "ifid_npc",   ifid_npc,            e.npc);
            chk(e.tag, "ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
            chk(e.tag, "halted",     {31'b0, halted},     {31'b0, e.halted});
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One clock edge with the current inputs, then compare against expectation.
    task automatic step(input string tag, input logic ren, input logic [31:0] addr,
                        input logic [31:0] instr, input logic [31:0] npc,
                        input logic valid, input logic hl);
        push(tag, ren, addr, instr, npc, valid, hl);
        tick();
        pop_check();
    endtask

    initial begin
        // 1: reset
        #2 nRST = 1'b0;
        #1;
        push("rst_async", 0, 32'h0, 32'h0, 32'h0, 0, 0); pop_check();
        repeat (3) tick();
        push("rst_hold", 0, 32'h0, 32'h0, 32'h0, 0, 0); pop_check();
        nRST = 1'b1;
        #1;
        push("idle", 0, 32'h0, 32'h0, 32'h0, 0, 0); pop_check();
        ihit = 1'b1; imemload = 32'h2401_0001;
        step("idle2fetch", 1, 32'h0, 32'h0, 32'h0, 0, 0);

        // 2: back-to-back hits
        step("hit0", 1, 32'h4, 32'h2401_0001, 32'h4, 1, 0);
        imemload = 32'h2402_0002;
        step("hit1", 1, 32'h8, 32'h2402_0002, 32'h8, 1, 0);

        // 3: misses hold pc and insert bubbles (npc held)
        ihit = 1'b0; imemload = 32'hBAD0_0000;
        step("miss0", 1, 32'h8, 32'h0, 32'h8, 0, 0);
        step("miss1", 1, 32'h8, 32'h0, 32'h8, 0, 0);

        // 4: stall with hits
        ihit = 1'b1; imemload = 32'h2403_0003;
        step("hit2", 1, 32'hC, 32'h2403_0003, 32'hC, 1, 0);
        stall = 1'b1; imemload = 32'hDEAD_BEEF;
        step("stall0", 1, 32'hC, 32'h2403_0003, 32'hC, 1, 0);
        step("stall1", 1, 32'hC, 32'h2403_0003, 32'hC, 1, 0);
        step("stall2", 1, 32'hC, 32'h2403_0003, 32'hC, 1, 0);
        stall = 1'b0; imemload = 32'h2404_0004;
        step("resume", 1, 32'h10, 32'h2404_0004, 32'h10, 1, 0);

        // 5: redirect + flush, with and without stall
        redirect = 1'b1; redirect_pc = 32'h103; flush = 1'b1; imemload = 32'hDEAD_0001;
        step("redir_flush", 1, 32'h100, 32'h0, 32'h0, 0, 0);
        redirect = 1'b0; flush = 1'b0; imemload = 32'h1111_1111;
        step("hit_100", 1, 32'h104, 32'h1111_1111, 32'h104, 1, 0);
        redirect = 1'b1; redirect_pc = 32'h203; flush = 1'b1; stall = 1'b1;
        step("redir_flush_stall", 1, 32'h200, 32'h0, 32'h0, 0, 0);
        redirect = 1'b0; flush = 1'b0; stall = 1'b0; imemload = 32'h2222_2222;
        step("hit_200", 1, 32'h204, 32'h2222_2222, 32'h204, 1, 0);
        redirect = 1'b1; redirect_pc = 32'h300; imemload = 32'hDEAD_0002;
        step("redir_noflush", 1, 32'h300, 32'h0, 32'h204, 0, 0);
        redirect = 1'b1; redirect_pc = 32'h401; stall = 1'b1;
        step("redir_stall", 1, 32'h400, 32'h0, 32'h204, 0, 0);
        stall = 1'b0;

        // pc wrap at 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; flush = 1'b1;
        step("redir_top", 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
        redirect = 1'b0; flush = 1'b0; imemload = 32'h3333_3333;
        step("wrap", 1, 32'h0, 32'h3333_3333, 32'h0, 1, 0);

        // 6: halt with flush is ignored, halt alone is terminal
        halt = 1'b1; flush = 1'b1; imemload = 32'hDEAD_0003;
        step("halt_flushed", 1, 32'h4, 32'h0, 32'h0, 0, 0);
        halt = 1'b0; flush = 1'b0; imemload = 32'h4444_4444;
        step("hit_4", 1, 32'h8, 32'h4444_4444, 32'h8, 1, 0);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; imemload = 32'h5555_5555;
        step("halt", 0, 32'h8, 32'h4444_4444, 32'h8, 1, 1);
        for (int i = 0; i < 10; i++) begin
            halt = i[0]; flush = i[1]; redirect = i[2]; stall = i[3];
            redirect_pc = 32'h600 + i; ihit = ~i[0];
            step($sformatf("halted_%0d", i), 0, 32'h8, 32'h4444_4444, 32'h8, 1, 1);
        end

        // async reset mid-operation
        nRST = 1'b0;
        #1;
        push("rst_mid", 0, 32'h0, 32'h0, 32'h0, 0, 0); pop_check();
        tick();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
